// File: rtl/alu_result_fifo.sv
// alu_result_fifo: show-ahead FIFO that buffers {C,Z,N,V,result[3:0]} bytes
// from the 4-bit ALU, with valid/ready on both sides, occupancy/full/empty
// status and a sticky drop error.
// Optional feature macro: ALU_STICKY_FLAGS_EN (accumulates the OR of the
// flags of every accepted entry on sticky_flags; otherwise tied to zero).
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_result,
    input  logic [3:0]    in_flags,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          drop_err,
    input  logic          clr_err,
    output logic [3:0]    sticky_flags
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          drop_err_q, drop_err_d;
    logic          push, pop;

    // Status and handshakes come only from registered state, so in_ready
    // never depends on out_ready combinationally.
    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign count     = count_q;
    assign drop_err  = drop_err_q;
    assign push      = ena & in_valid & in_ready;
    assign pop       = ena & out_valid & out_ready;

    // Show-ahead head entry; forced to zero while empty.
    assign out_data  = empty ? 8'h00 : mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and the sticky drop error.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_err_d = drop_err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        // A new drop takes priority over a clear in the same cycle.
        if (ena) begin
            if (in_valid && full) begin
                drop_err_d = 1'b1;
            end else if (clr_err) begin
                drop_err_d = 1'b0;
            end
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_flags, in_result};
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    logic [3:0] sticky_q, sticky_d;

    // Clear first, then OR in the flags of an entry accepted this cycle.
    always_comb begin
        sticky_d = sticky_q;
        if (ena) begin
            sticky_d = (clr_err ? 4'h0 : sticky_q) | (push ? in_flags : 4'h0);
        end
    end

    // Sticky flag accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 4'h0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`else
    assign sticky_flags = 4'h0;
`endif

endmodule
